eth_tx_fcs_arb: RTL and testbench

ETH_TX_FCS_ARB -- requirements
Module: eth_tx_fcs_arb

---
 rtl/eth_tx_fcs_arb.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_fcs_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_fcs_arb.sv
// Two-port (ARP/UDP) Ethernet TX arbiter and framer.
// Wraps each granted payload in preamble/SFD, appends the FCS taken from an
// external byte-wide CRC-32 engine, and enforces the inter-frame gap.
module eth_tx_fcs_arb #(
  parameter int PRE_LEN    = 7,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_req,
  input  logic        udp_req,
  output logic        arp_gnt,
  output logic        udp_gnt,
  input  logic        arp_vld,
  input  logic        arp_last,
  input  logic [7:0]  arp_data,
  input  logic        udp_vld,
  input  logic        udp_last,
  input  logic [7:0]  udp_data,
  output logic        arp_rdy,
  output logic        udp_rdy,
  output logic        crc_en,
  output logic        crc_clr,
  output logic [7:0]  crc_d,
  input  logic [31:0] crc_data,
  output logic        tx_en,
  output logic        tx_er,
  output logic [7:0]  tx_data
);

  typedef enum logic [2:0] {IDLE, PRE, PAY, FCS, IFG} state_t;

  localparam int CNT_MAX = (PRE_LEN > IFG_CYCLES) ? ((PRE_LEN > 4) ? PRE_LEN : 4)
                                                  : ((IFG_CYCLES > 4) ? IFG_CYCLES : 4);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
  localparam logic [CW-1:0] FCS_LAST = CW'(3);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          arp_gnt_reg, arp_gnt_next;
  logic          udp_gnt_reg, udp_gnt_next;
  logic          last_udp_reg, last_udp_next;   // 1: UDP was the last port served
  logic          clr_hold_reg;                  // keeps crc_clr high through reset
  logic          tx_en_reg, tx_en_next;
  logic          tx_er_reg, tx_er_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          clr_pulse;

  logic          sel_vld, sel_last;
  logic [7:0]    sel_data;
  logic [7:0]    fcs_byte [4];

  // FCS byte k: inverted CRC bits (31-8k)..(24-8k), bit (24-8k) landing in the MSB
  for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
    for (genvar gj = 0; gj < 8; gj++) begin : g_bit
      assign fcs_byte[gi][gj] = ~crc_data[31 - 8*gi - gj];
    end
  end

  assign sel_vld  = udp_gnt_reg ? udp_vld  : arp_vld;
  assign sel_last = udp_gnt_reg ? udp_last : arp_last;
  assign sel_data = udp_gnt_reg ? udp_data : arp_data;

  assign arp_gnt = arp_gnt_reg;
  assign udp_gnt = udp_gnt_reg;
  assign tx_en   = tx_en_reg;
  assign tx_er   = tx_er_reg;
  assign tx_data = tx_data_reg;
  assign crc_clr = clr_hold_reg | clr_pulse;

  // State, grant and output-byte registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      arp_gnt_reg  <= 1'b0;
      udp_gnt_reg  <= 1'b0;
      last_udp_reg <= 1'b1;
      clr_hold_reg <= 1'b1;
      tx_en_reg    <= 1'b0;
      tx_er_reg    <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      arp_gnt_reg  <= arp_gnt_next;
      udp_gnt_reg  <= udp_gnt_next;
      last_udp_reg <= last_udp_next;
      clr_hold_reg <= 1'b0;
      tx_en_reg    <= tx_en_next;
      tx_er_reg    <= tx_er_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  // Next-state, arbitration, source handshake and CRC engine control
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    arp_gnt_next  = arp_gnt_reg;
    udp_gnt_next  = udp_gnt_reg;
    last_udp_next = last_udp_reg;
    tx_en_next    = 1'b0;
    tx_er_next    = 1'b0;
    tx_data_next  = 8'h00;
    arp_rdy       = 1'b0;
    udp_rdy       = 1'b0;
    crc_en        = 1'b0;
    crc_d         = 8'h00;
    clr_pulse     = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the port that was not served last wins
        if (arp_req && (!udp_req || last_udp_reg)) begin
          arp_gnt_next  = 1'b1;
          last_udp_next = 1'b0;
          state_next    = PRE;
          cnt_next      = '0;
        end else if (udp_req) begin
          udp_gnt_next  = 1'b1;
          last_udp_next = 1'b1;
          state_next    = PRE;
          cnt_next      = '0;
        end
      end
      PRE: begin
        tx_en_next   = 1'b1;
        tx_data_next = (cnt_reg == PRE_LAST) ? 8'hD5 : 8'h55;
        if (cnt_reg == PRE_LAST) begin
          state_next = PAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PAY: begin
        arp_rdy = arp_gnt_reg;
        udp_rdy = udp_gnt_reg;
        crc_d   = sel_data;
        tx_en_next = 1'b1;
        if (sel_vld) begin
          crc_en       = 1'b1;
          tx_data_next = sel_data;
          if (sel_last) begin
            state_next = FCS;
            cnt_next   = '0;
          end
        end else begin
          // Underrun: poison the frame, reset the engine, skip the FCS
          tx_er_next   = 1'b1;
          clr_pulse    = 1'b1;
          arp_gnt_next = 1'b0;
          udp_gnt_next = 1'b0;
          state_next   = IFG;
          cnt_next     = '0;
        end
      end
      FCS: begin
        tx_en_next   = 1'b1;
        tx_data_next = fcs_byte[cnt_reg[1:0]];
        if (cnt_reg == FCS_LAST) begin
          // Engine clears on the same edge that captures the final FCS byte
          clr_pulse    = 1'b1;
          arp_gnt_next = 1'b0;
          udp_gnt_next = 1'b0;
          state_next   = IFG;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      IFG: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_fcs_arb.sv
// Bench for eth_tx_fcs_arb: directed scenarios plus randomized frames,
// checked against a reflected-CRC reference and a round-robin model.
module tb_eth_tx_fcs_arb;

  typedef logic [7:0] byte_q [$];

  localparam int PRE = 7;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_req, udp_req, arp_gnt, udp_gnt;
  logic        arp_vld, arp_last, udp_vld, udp_last;
  logic [7:0]  arp_data, udp_data;
  logic        arp_rdy, udp_rdy, crc_en, crc_clr;
  logic [7:0]  crc_d;
  logic [31:0] eng_reg;
  logic        tx_en, tx_er;
  logic [7:0]  tx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit last_udp = 1'b1;

  `define CHK(TAG, OBS, EXP) begin n_cmp++; assert ((OBS) === (EXP)) else begin n_bad++; $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); end end

  eth_tx_fcs_arb #(.PRE_LEN(PRE), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst),
    .arp_req(arp_req), .udp_req(udp_req), .arp_gnt(arp_gnt), .udp_gnt(udp_gnt),
    .arp_vld(arp_vld), .arp_last(arp_last), .arp_data(arp_data),
    .udp_vld(udp_vld), .udp_last(udp_last), .udp_data(udp_data),
    .arp_rdy(arp_rdy), .udp_rdy(udp_rdy),
    .crc_en(crc_en), .crc_clr(crc_clr), .crc_d(crc_d), .crc_data(eng_reg),
    .tx_en(tx_en), .tx_er(tx_er), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-serial CRC-32 engine (MSB-first register, bytes fed LSB first)
  function automatic logic [31:0] eng_step(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] c;
    c = r;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (crc_clr)     eng_reg <= 32'hFFFFFFFF;
    else if (crc_en) eng_reg <= eng_step(eng_reg, crc_d);
  end

  // Reference FCS value: standard reflected CRC-32; sent least significant byte first
  function automatic logic [31:0] ref_fcs(input byte_q p);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (p[i]) begin
      c = c ^ {24'h0, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame monitor: collects {tx_er,tx_data} per frame; a frame cut by reset is dropped
  logic [8:0] rx_q [$];
  int len_q [$];
  int start_q [$];
  int cur_n = 0;
  bit in_frame = 0;
  bit seen_any = 0;
  int low_run = 0;
  int last_gap = 0;
  int frames_done = 0;
  int frames_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < cur_n; i++) void'(rx_q.pop_back());
      cur_n    <= 0;
      in_frame <= 0;
      low_run  <= 0;
    end else if (tx_en) begin
      if (!in_frame) begin
        in_frame <= 1;
        start_q.push_back(cyc);
        if (seen_any) last_gap <= low_run;
      end
      rx_q.push_back({tx_er, tx_data});
      cur_n <= cur_n + 1;
    end else begin
      if (in_frame) begin
        in_frame <= 0;
        len_q.push_back(cur_n);
        cur_n       <= 0;
        seen_any    <= 1;
        frames_done <= frames_done + 1;
        low_run     <= 1;
      end else begin
        low_run <= low_run + 1;
      end
    end
  end

  task automatic set_src(input bit port, input logic v, input logic l, input logic [7:0] d);
    if (port) begin udp_vld = v; udp_last = l; udp_data = d; end
    else      begin arp_vld = v; arp_last = l; arp_data = d; end
  endtask

  task automatic rand_bytes(input int n, output byte_q p);
    p = {};
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_udp = 1'b1;
    @(posedge clk); #1;
  endtask

  // Raise req, wait for the grant; k = negedges until grant seen, rc = request cycle
  task automatic request(input bit port, output int k, output int rc);
    @(posedge clk); #1;
    if (port) udp_req = 1'b1; else arp_req = 1'b1;
    rc = cyc;
    k  = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if ((port ? udp_gnt : arp_gnt) === 1'b1) begin k = i; break; end
    end
    if (port) udp_req = 1'b0; else arp_req = 1'b0;
    if (k == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL gnt_timeout: observed no grant expected grant on port %0d", port);
    end
    last_udp = port;
  endtask

  // Deliver payload bytes on rdy; byte index ab (if >=0) is withheld to cause an underrun
  task automatic feed(input bit port, input byte_q p, input int ab);
    int n;
    bit ok;
    bit first;
    n = p.size();
    first = 1;
    set_src(port, ab != 0, n == 1, p[0]);
    for (int i = 0; i < n; i++) begin
      ok = 0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if ((port ? udp_rdy : arp_rdy) === 1'b1) begin ok = 1; break; end
      end
      if (!ok) begin
        n_cmp++; n_bad++;
        $error("FAIL rdy_timeout: observed rdy low expected rdy high at byte %0d", i);
        break;
      end
      if (first) begin
        `CHK("other_rdy_low", (port ? arp_rdy : udp_rdy), 1'b0)
        first = 0;
      end
      @(posedge clk); #1;
      if (i == ab) break;
      if (i + 1 < n) set_src(port, (i + 1) != ab, (i + 1) == (n - 1), p[i + 1]);
    end
    set_src(port, 1'b0, 1'b0, 8'h00);
  endtask

  // Compare the next completed frame with preamble/SFD + payload + FCS (or error byte)
  task automatic check_frame(input byte_q p, input int ab, input logic [31:0] fcs, output int st);
    logic [8:0] exp_q [$];
    logic [8:0] got;
    int len;
    int npay;
    bit ok;
    exp_q = {};
    for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    npay = (ab < 0) ? p.size() : ab;
    for (int i = 0; i < npay; i++) exp_q.push_back({1'b0, p[i]});
    if (ab < 0) for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, fcs[8*b +: 8]});
    else        exp_q.push_back({1'b1, 8'h00});
    ok = 0;
    st = -1;
    for (int w = 0; w < 600; w++) begin
      @(negedge clk); #1;
      if (frames_done > frames_seen) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $error("FAIL frame_timeout: observed no frame end expected frame of %0d bytes", exp_q.size());
      return;
    end
    frames_seen++;
    len = len_q.pop_front();
    st  = start_q.pop_front();
    `CHK("frame_len", len, exp_q.size())
    for (int i = 0; i < len; i++) begin
      got = rx_q.pop_front();
      if (i < exp_q.size()) `CHK($sformatf("frame_byte%0d", i), got, exp_q[i])
    end
    `CHK("gnt_released", {arp_gnt, udp_gnt}, 2'b00)
  endtask

  task automatic tie(input byte_q pa, input byte_q pb);
    bit exp_udp;
    bit ok;
    int k, rc, st;
    exp_udp = !last_udp;
    ok = 0;
    @(posedge clk); #1;
    arp_req = 1'b1;
    udp_req = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if ((arp_gnt | udp_gnt) === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $error("FAIL tie_timeout: observed no grant expected one grant");
      arp_req = 1'b0; udp_req = 1'b0;
      return;
    end
    `CHK("tie_winner_udp", udp_gnt, exp_udp)
    `CHK("tie_loser_gnt", (exp_udp ? arp_gnt : udp_gnt), 1'b0)
    if (exp_udp) udp_req = 1'b0; else arp_req = 1'b0;
    last_udp = exp_udp;
    feed(exp_udp, exp_udp ? pb : pa, -1);
    check_frame(exp_udp ? pb : pa, -1, ref_fcs(exp_udp ? pb : pa), st);
    request(!exp_udp, k, rc);
    feed(!exp_udp, exp_udp ? pa : pb, -1);
    check_frame(exp_udp ? pa : pb, -1, ref_fcs(exp_udp ? pa : pb), st);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q p, q;
    int k, rc, st, n, ab;
    bit port;

    arp_req = 0; udp_req = 0;
    arp_vld = 0; arp_last = 0; arp_data = 0;
    udp_vld = 0; udp_last = 0; udp_data = 0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("rst_tx_en", tx_en, 1'b0)
    `CHK("rst_tx_er", tx_er, 1'b0)
    `CHK("rst_tx_data", tx_data, 8'h00)
    `CHK("rst_gnt", {arp_gnt, udp_gnt}, 2'b00)
    `CHK("rst_rdy", {arp_rdy, udp_rdy}, 2'b00)
    `CHK("rst_crc_en", crc_en, 1'b0)
    `CHK("rst_crc_d", crc_d, 8'h00)
    `CHK("rst_crc_clr", crc_clr, 1'b1)
    @(posedge clk); #1 rst = 1'b0;
    `CHK("crc_clr_until_edge", crc_clr, 1'b1)
    @(posedge clk); #1;
    `CHK("crc_clr_dropped", crc_clr, 1'b0)

    // "123456789" from ARP, exact cycle placement
    p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    request(1'b0, k, rc);
    `CHK("gnt_latency", k, 2)
    feed(1'b0, p, -1);
    check_frame(p, -1, 32'hCBF43926, st);
    `CHK("tx_start_cycle", st, rc + 2)

    // One-byte 0x00 payload: CRC value D202EF8D, on the wire 8D EF 02 D2
    p = {8'h00};
    request(1'b1, k, rc);
    feed(1'b1, p, -1);
    check_frame(p, -1, 32'hD202EF8D, st);

    // Ties after reset: ARP, then UDP, then ARP again
    do_reset();
    rand_bytes(5, p); rand_bytes(7, q);
    tie(p, q);
    rand_bytes(3, p); rand_bytes(4, q);
    tie(p, q);

    // Back-to-back UDP frames: gap and engine clear between frames
    rand_bytes(10, p);
    request(1'b1, k, rc); feed(1'b1, p, -1); check_frame(p, -1, ref_fcs(p), st);
    rand_bytes(6, p);
    request(1'b1, k, rc); feed(1'b1, p, -1); check_frame(p, -1, ref_fcs(p), st);
    `CHK("ifg_gap_ok", (last_gap >= IFG), 1'b1)

    // Underrun on the 3rd payload cycle, then a clean frame
    rand_bytes(6, p);
    request(1'b1, k, rc); feed(1'b1, p, 2); check_frame(p, 2, 32'h0, st);
    rand_bytes(8, p);
    request(1'b0, k, rc); feed(1'b0, p, -1); check_frame(p, -1, ref_fcs(p), st);

    // Reset mid-payload
    request(1'b1, k, rc);
    set_src(1'b1, 1'b1, 1'b0, 8'hA5);
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (udp_rdy === 1'b1) break;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    `CHK("midrst_tx_en", tx_en, 1'b0)
    `CHK("midrst_tx_er", tx_er, 1'b0)
    `CHK("midrst_gnt", {arp_gnt, udp_gnt}, 2'b00)
    `CHK("midrst_rdy", {arp_rdy, udp_rdy}, 2'b00)
    `CHK("midrst_crc_en", crc_en, 1'b0)
    `CHK("midrst_crc_clr", crc_clr, 1'b1)
    set_src(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_udp = 1'b1;
    `CHK("midrst_clr_held", crc_clr, 1'b1)
    @(posedge clk); #1;
    `CHK("midrst_clr_dropped", crc_clr, 1'b0)
    rand_bytes(7, p);
    request(1'b0, k, rc); feed(1'b0, p, -1); check_frame(p, -1, ref_fcs(p), st);

    // Randomized frames, aborts and ties
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_bytes($urandom_range(1, 12), p);
        rand_bytes($urandom_range(1, 12), q);
        tie(p, q);
      end else begin
        port = 1'($urandom_range(0, 1));
        n = $urandom_range(1, 16);
        rand_bytes(n, p);
        ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
        request(port, k, rc);
        feed(port, p, ab);
        check_frame(p, ab, ref_fcs(p), st);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
